// File: rtl/plic_claim_pkg.sv
// Shared types and defaults for the PLIC claim/complete sequencer.
// The FSM encoding and the APB command register layout live here so the top and the bench agree.
package plic_claim_pkg;

    localparam int PLIC_CLAIM_DEPTH   = 4;
    localparam int PLIC_CLAIM_HOLDOFF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } claim_state_e;

    // The id field is already zero-extended to the APB data width, so it drives pwdata directly.
    typedef struct packed {
        logic        write;
        logic [31:0] id;
    } apb_cmd_t;

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// APB4 bus between the claim sequencer (master) and the PLIC register slave.
interface plic_claim_ctrl_if;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/plic_claim_fifo.sv
// Synchronous FIFO for claimed interrupt IDs; head is read straight from storage.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module plic_claim_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete sequencer: claims IDs over APB into a FIFO and forwards hart completions.
// Optional access-phase timeout is compiled in with `define PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_ctrl
    import plic_claim_pkg::*;
#(
    parameter int          ID_WIDTH   = 5,
    parameter int          DEPTH      = PLIC_CLAIM_DEPTH,
    parameter logic [31:0] CLAIM_ADDR = 32'h0000_0020,
    parameter int          HOLDOFF    = PLIC_CLAIM_HOLDOFF,
    parameter int          TIMEOUT    = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                irq_i,
    plic_claim_ctrl_if.master   apb,
    // Handshakes: a transfer happens on a cycle where valid and ready are both 1; a source
    // holds valid and its payload (id_o, comp_id) stable until that cycle.
    output logic                id_valid,
    input  logic                id_ready,
    output logic [ID_WIDTH-1:0] id_o,
    input  logic                comp_valid,
    output logic                comp_ready,
    input  logic [ID_WIDTH-1:0] comp_id,
    output logic                err_o,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETUP  = ST_SETUP;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;
    localparam logic [1:0] S_HOLD   = ST_HOLD;

    localparam int             HCW       = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLDOFF);

    logic [1:0]          state;
    apb_cmd_t            cmd;
    logic [HCW-1:0]      hold_cnt;
    logic                psel_q;
    logic                penable_q;
    logic [31:0]         paddr_q;
    logic                err_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                claim_ok;
    logic                start;
    logic                tmo_hit;
    logic                xfer_done;
    logic                push;
    logic [ID_WIDTH-1:0] rd_id;
    logic                unused_prdata;

`ifdef PLIC_CLAIM_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tmo_cnt;

    assign tmo_hit = (state == S_ACCESS) && !apb.pready && (tmo_cnt == TCW'(TIMEOUT - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt <= '0;
        end else if (state != S_ACCESS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign rd_id         = apb.prdata[ID_WIDTH-1:0];
    assign unused_prdata = ^apb.prdata[31:ID_WIDTH];

    // Completion has priority; a claim also needs room in the FIFO and an expired holdoff.
    assign claim_ok   = irq_i && !fifo_full && (hold_cnt == '0);
    assign start      = comp_valid || claim_ok;
    assign xfer_done  = (state == S_ACCESS) && (apb.pready || tmo_hit);
    assign comp_ready = xfer_done && cmd.write;
    assign push       = (state == S_ACCESS) && apb.pready && !cmd.write && !apb.pslverr
                        && (rd_id != '0);

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = cmd.write;
    assign apb.pwdata  = cmd.id;
    assign err_o       = err_q;
    assign id_valid    = !fifo_empty;
    assign dbg_state   = state;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= S_IDLE;
            cmd       <= '0;
            hold_cnt  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state == S_ACCESS) && ((apb.pready && apb.pslverr) || tmo_hit)) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SETUP;
                        psel_q    <= 1'b1;
                        paddr_q   <= CLAIM_ADDR;
                        cmd.write <= comp_valid;
                        cmd.id    <= comp_valid ? 32'(comp_id) : 32'd0;
                    end
                end
                S_SETUP: begin
                    state     <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (xfer_done) begin
                        state     <= S_HOLD;
                        hold_cnt  <= HOLD_LOAD;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        cmd       <= '0;
                    end
                end
                default: begin
                    // HOLD lasts HOLDOFF cycles, and at least one.
                    if (hold_cnt <= HCW'(1)) begin
                        state    <= S_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    plic_claim_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_WIDTH)
    ) u_fifo (
        .clk       (pclk),
        .rst_n     (presetn),
        .push      (push),
        .push_data (rd_id),
        .pop       (id_valid && id_ready),
        .head      (id_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: APB slave model, directed latency/priority/full/error/reset cases,
// then randomized claims and completions checked by a transaction-level scoreboard.
module tb_plic_claim_ctrl;
  import plic_claim_pkg::*;

  localparam int          ID_W       = 5;
  localparam logic [31:0] CLAIM_ADDR = 32'h0000_0020;

  logic            pclk       = 1'b0;
  logic            presetn    = 1'b1;
  logic            irq_i      = 1'b0;
  logic            id_ready   = 1'b0;
  logic            comp_valid = 1'b0;
  logic [ID_W-1:0] comp_id    = '0;
  logic            id_valid;
  logic [ID_W-1:0] id_o;
  logic            comp_ready;
  logic            err_o;
  logic [1:0]      dbg_state;

  plic_claim_ctrl_if apb_bus ();

  plic_claim_ctrl #(
    .ID_WIDTH   (ID_W),
    .DEPTH      (4),
    .CLAIM_ADDR (CLAIM_ADDR),
    .HOLDOFF    (2),
    .TIMEOUT    (16)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .irq_i      (irq_i),
    .apb        (apb_bus),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_o       (id_o),
    .comp_valid (comp_valid),
    .comp_ready (comp_ready),
    .comp_id    (comp_id),
    .err_o      (err_o),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 pclk = ~pclk;

  // scoreboard state
  logic [ID_W-1:0] exp_id_q[$];
  logic [ID_W-1:0] exp_wr_q[$];
  logic            exp_err   = 1'b0;
  int              tests_run = 0;
  int              fails     = 0;
  int              rd_count  = 0;
  int              wr_count  = 0;

  // slave model controls
  bit          rand_mode = 1'b0;
  bit          stall     = 1'b0;
  int          max_wait  = 0;
  int          wait_left = 0;
  logic [31:0] rd_fixed  = '0;
  logic        err_fixed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests_run++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step();
      if (dbg_state == st) hit = 1'b1;
    end
    if (!hit) flag_fail(name);
  endtask

  task automatic drain();
    bit done = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 24 && !done; i++) begin
      step();
      if (!id_valid) done = 1'b1;
    end
    id_ready = 1'b0;
    check("drain_empty", id_valid, 1'b0);
  endtask

  task automatic do_complete(input logic [ID_W-1:0] id);
    bit got = 1'b0;
    comp_valid = 1'b1;
    comp_id    = id;
    exp_wr_q.push_back(id);
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (comp_ready) got = 1'b1;
    end
    check("comp_handshake", got, 1'b1);
    step();
    comp_valid = 1'b0;
  endtask

  // APB slave model: a read answer decides what the hart should later see.
  always @(negedge pclk) begin
    logic [31:0] v;
    logic        e;
    if (apb_bus.psel && apb_bus.penable && !stall) begin
      if (wait_left > 0) begin
        wait_left--;
        apb_bus.pready = 1'b0;
      end else begin
        if (rand_mode) begin
          v = $urandom;
          if ($urandom_range(0, 3) == 0) v[ID_W-1:0] = '0;
          e = ($urandom_range(0, 15) == 0);
        end else begin
          v = rd_fixed;
          e = err_fixed;
        end
        apb_bus.pready  = 1'b1;
        apb_bus.prdata  = v;
        apb_bus.pslverr = e;
        if (e) exp_err = 1'b1;
        else if (!apb_bus.pwrite && v[ID_W-1:0] != '0) exp_id_q.push_back(v[ID_W-1:0]);
      end
    end else begin
      apb_bus.pready  = 1'b0;
      apb_bus.pslverr = 1'b0;
      apb_bus.prdata  = '0;
      wait_left       = $urandom_range(0, max_wait);
    end
  end

  // monitor: compares every completed transfer and every popped ID
  always begin
    @(negedge pclk);
    #2;
    if (presetn) begin
      if (apb_bus.psel && !apb_bus.penable) check("setup_addr", apb_bus.paddr, CLAIM_ADDR);
      if (apb_bus.psel && apb_bus.penable && apb_bus.pready) begin
        check("xfer_addr", apb_bus.paddr, CLAIM_ADDR);
        if (apb_bus.pwrite) begin
          wr_count++;
          if (exp_wr_q.size() == 0) flag_fail("wr_unexpected");
          else check("wr_data", apb_bus.pwdata, 32'(exp_wr_q.pop_front()));
          check("wr_ack", comp_ready, 1'b1);
        end else begin
          rd_count++;
          check("rd_no_ack", comp_ready, 1'b0);
        end
      end
      if (id_valid && id_ready) begin
        if (exp_id_q.size() == 0) flag_fail("id_unexpected");
        else check("id_out", id_o, exp_id_q.pop_front());
      end
    end
  end

  initial begin
    int r0;
    int n;
    #3 presetn = 1'b0;
    step();
    check("rst_psel", apb_bus.psel, 1'b0);
    check("rst_penable", apb_bus.penable, 1'b0);
    check("rst_pwrite", apb_bus.pwrite, 1'b0);
    check("rst_paddr", apb_bus.paddr, 32'd0);
    check("rst_pwdata", apb_bus.pwdata, 32'd0);
    check("rst_comp_ready", comp_ready, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_o", id_o, '0);
    check("rst_err", err_o, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    step();
    presetn = 1'b1;
    repeat (2) step();

    // claim latency and holdoff
    irq_i = 1'b1;
    rd_fixed = 32'd3;
    step();
    check("claim_psel", apb_bus.psel, 1'b1);
    check("claim_setup_penable", apb_bus.penable, 1'b0);
    check("claim_pwrite", apb_bus.pwrite, 1'b0);
    check("claim_pwdata", apb_bus.pwdata, 32'd0);
    step();
    check("claim_access", apb_bus.penable, 1'b1);
    step();
    check("claim_released", apb_bus.psel, 1'b0);
    check("claim_id_valid", id_valid, 1'b1);
    check("claim_id_o", id_o, 5'd3);
    step();
    check("holdoff_1", apb_bus.psel, 1'b0);
    step();
    check("holdoff_2", apb_bus.psel, 1'b0);
    rd_fixed = 32'd4;
    step();
    check("reclaim_psel", apb_bus.psel, 1'b1);
    irq_i = 1'b0;
    step();
    check("irq_drop_no_abort", apb_bus.penable, 1'b1);

    // completion latency
    wait_state(ST_IDLE, "idle_before_comp");
    comp_valid = 1'b1;
    comp_id = 5'd3;
    exp_wr_q.push_back(5'd3);
    step();
    check("comp_psel", apb_bus.psel, 1'b1);
    check("comp_pwrite", apb_bus.pwrite, 1'b1);
    check("comp_pwdata", apb_bus.pwdata, 32'd3);
    check("comp_early", comp_ready, 1'b0);
    step();
    check("comp_ready", comp_ready, 1'b1);
    step();
    comp_valid = 1'b0;
    check("comp_single_pulse", comp_ready, 1'b0);

    // completion beats claim in the same IDLE cycle
    wait_state(ST_IDLE, "idle_before_prio");
    irq_i = 1'b1;
    rd_fixed = 32'd6;
    comp_valid = 1'b1;
    comp_id = 5'd9;
    exp_wr_q.push_back(5'd9);
    step();
    check("prio_write_first", apb_bus.pwrite, 1'b1);
    step();
    check("prio_comp_ready", comp_ready, 1'b1);
    step();
    comp_valid = 1'b0;
    wait_state(ST_SETUP, "prio_read_next");
    check("prio_read_second", apb_bus.pwrite, 1'b0);
    irq_i = 1'b0;
    wait_state(ST_IDLE, "idle_after_prio");
    drain();

    // full FIFO stops claiming until a pop
    irq_i = 1'b1;
    rd_fixed = 32'd7;
    r0 = rd_count;
    repeat (40) step();
    check("full_reads", rd_count - r0, 4);
    check("full_no_psel", apb_bus.psel, 1'b0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    wait_state(ST_SETUP, "full_resume");
    wait_state(ST_IDLE, "full_resume_idle");
    check("full_reads_after_pop", rd_count - r0, 5);
    irq_i = 1'b0;
    drain();

    // ID 0 is dropped; slave error is not pushed and sets err_o
    irq_i = 1'b1;
    rd_fixed = 32'd0;
    wait_state(ST_SETUP, "zero_setup");
    irq_i = 1'b0;
    wait_state(ST_IDLE, "zero_idle");
    check("zero_no_push", id_valid, 1'b0);
    check("zero_no_err", err_o, 1'b0);
    irq_i = 1'b1;
    rd_fixed = 32'd5;
    err_fixed = 1'b1;
    wait_state(ST_SETUP, "err_setup");
    irq_i = 1'b0;
    wait_state(ST_IDLE, "err_idle");
    err_fixed = 1'b0;
    check("err_no_push", id_valid, 1'b0);
    check("err_set", err_o, 1'b1);

    // randomized claims, completions, slave wait states and pops
    rand_mode = 1'b1;
    max_wait = 3;
    fork
      begin
        repeat (600) begin
          step();
          irq_i = ($urandom_range(0, 2) != 0);
          id_ready = ($urandom_range(0, 1) != 0);
        end
        irq_i = 1'b0;
        id_ready = 1'b0;
      end
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 8)) step();
          do_complete(ID_W'($urandom_range(1, 31)));
        end
      end
    join
    repeat (10) step();
    drain();
    rand_mode = 1'b0;
    max_wait = 0;
    check("rand_err", err_o, exp_err);

`ifdef PLIC_CLAIM_TIMEOUT_EN
    stall = 1'b1;
    irq_i = 1'b1;
    wait_state(ST_ACCESS, "tmo_access");
    irq_i = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!apb_bus.penable) break;
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_psel", apb_bus.psel, 1'b0);
    check("tmo_err", err_o, 1'b1);
    check("tmo_no_push", id_valid, 1'b0);
    stall = 1'b0;
    wait_state(ST_IDLE, "tmo_idle");
`else
    n = 0;
`endif

    // reset in ACCESS with an ID still queued
    rd_fixed = 32'd2;
    irq_i = 1'b1;
    wait_state(ST_SETUP, "pre_rst_setup");
    irq_i = 1'b0;
    wait_state(ST_IDLE, "pre_rst_idle");
    check("pre_rst_queued", id_valid, 1'b1);
    stall = 1'b1;
    irq_i = 1'b1;
    wait_state(ST_ACCESS, "rst_access");
    #1 presetn = 1'b0;
    #1;
    exp_id_q.delete();
    exp_err = 1'b0;
    check("midrst_psel", apb_bus.psel, 1'b0);
    check("midrst_penable", apb_bus.penable, 1'b0);
    check("midrst_paddr", apb_bus.paddr, 32'd0);
    check("midrst_pwdata", apb_bus.pwdata, 32'd0);
    check("midrst_comp_ready", comp_ready, 1'b0);
    check("midrst_id_valid", id_valid, 1'b0);
    check("midrst_id_o", id_o, '0);
    check("midrst_err", err_o, 1'b0);
    irq_i = 1'b0;
    stall = 1'b0;
    step();
    presetn = 1'b1;
    step();

    // normal operation after reset
    rd_fixed = 32'd9;
    irq_i = 1'b1;
    wait_state(ST_SETUP, "post_rst_setup");
    irq_i = 1'b0;
    wait_state(ST_IDLE, "post_rst_idle");
    check("post_rst_id", id_o, 5'd9);
    drain();

    check("exp_id_q_empty", exp_id_q.size(), 0);
    check("exp_wr_q_empty", exp_wr_q.size(), 0);
    check("final_err", err_o, exp_err);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/plic_claim_ctrl.md
# plic_claim_ctrl

Hardware claim/complete sequencer placed between a hart and the PLIC's APB4 slave port. It watches the PLIC interrupt output, issues APB4 reads of the CLAIMCOMP register to claim interrupt IDs, and buffers the claimed IDs in a small FIFO for the hart. It arbitrates hart completion requests, issued as APB4 writes of the ID to CLAIMCOMP, onto the same single APB4 master port. This removes software polling from the interrupt entry path.

## Interface
Parameters:
- `ID_WIDTH`, default 5: interrupt ID width; supports IDs 1..31.
- `DEPTH`, default 4: claimed-ID FIFO depth; must be a power of 2 and at least 2.
- `CLAIM_ADDR`, default 32'h0000_0020: full APB address of the CLAIMCOMP register.
- `HOLDOFF`, default 2: idle cycles after any transfer before `irq_i` is sampled again. This covers the PLIC's registered pending/irq update.
- `TIMEOUT`, default 16: access-phase cycle limit. Only used when the timeout feature is compiled in.

Ports:
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous active-low reset.
- `irq_i` in 1: PLIC `irq_o`.
- `paddr` out 32: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB write.
- `pwdata` out 32: APB write data.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.
- `id_valid` out 1: claimed-ID FIFO head valid.
- `id_ready` in 1: hart pops the FIFO head.
- `id_o` out ID_WIDTH: FIFO head ID.
- `comp_valid` in 1: hart completion request.
- `comp_ready` out 1: completion accepted.
- `comp_id` in ID_WIDTH: ID to complete.
- `err_o` out 1: sticky error flag; cleared only by reset.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE arbitration:
  - A completion is eligible when `comp_valid`=1.
  - A claim is eligible when `irq_i`=1, the FIFO is not full, and the holdoff counter is 0.
  - Completion wins when both are eligible.
  - The chosen command (write/read flag and `comp_id`) is latched on IDLE exit.
- SETUP:
  - `psel`=1, `penable`=0, `paddr`=CLAIM_ADDR.
  - For a write, `pwdata` = zero-extended latched ID. For a read, `pwdata`=0.
  - Always lasts exactly one cycle, then ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1; the state holds until `pready`=1.
  - On `pready`, go to HOLD and load holdoff counter = HOLDOFF.
- Read completion: if `prdata[ID_WIDTH-1:0]` is nonzero, push it into the FIFO. ID 0 means no interrupt and is dropped silently.
- Write completion: `comp_ready`=1 for exactly the `pready` cycle. `comp_id` must be held stable from `comp_valid` rise until `comp_ready`.
- `pslverr`=1 with `pready` sets `err_o`. The read is not pushed; the write is still acknowledged.
- HOLD: the holdoff counter decrements each cycle; return to IDLE when it reaches 0. With HOLDOFF=0, HOLD lasts one cycle.
- FIFO behaviour:
  - Pop when `id_valid` && `id_ready`.
  - A push and pop in the same cycle are both honoured, including when full.
  - Pointers are ID_WIDTH-independent, log2(DEPTH)+1 bits, and wrap naturally.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite`, `comp_ready`, `id_valid`, `err_o` = 0.
  - `paddr`, `pwdata`, `id_o` = 0.
  - FSM = IDLE, FIFO empty, holdoff counter = 0.
- Outputs to APB are registered from state.
- Latency with `pready` tied high:
  - `irq_i` rise → `psel` in the next cycle.
  - ID is visible on `id_o` 3 cycles after `irq_i` is sampled.
  - Completion: `comp_valid` sampled in IDLE → `comp_ready` 2 cycles later.
- `id_o` and `id_valid` are driven from FIFO registers; no combinational path from `prdata`.
- `irq_i` deasserting during SETUP or ACCESS does not abort the transfer.
- Reset mid-transfer drops `psel` immediately (asynchronous) and empties the FIFO.

## Configuration
- Macro `PLIC_CLAIM_TIMEOUT_EN`.
- Defined:
  - A counter runs in ACCESS.
  - After TIMEOUT cycles without `pready`: force `psel`/`penable` low, set `err_o`, go to HOLD.
  - A read pushes nothing; a write pulses `comp_ready`.
- Undefined: ACCESS waits indefinitely; no counter logic is present.

## Structure
- Shared package `plic_claim_pkg`:
  - FSM state enum.
  - APB command struct {write, id}.
  - Default constants (`PLIC_CLAIM_DEPTH`, `PLIC_CLAIM_HOLDOFF`).
- One sub-module `plic_claim_fifo` (parameterised synchronous FIFO: `DEPTH`, `WIDTH`, full/empty outputs).
- Top level holds the FSM, arbiter and counters.

## Test plan
- `irq_i`=1, slave returns `prdata`=3 → one read at 0x20; `id_valid`=1, `id_o`=3; no further read for HOLDOFF cycles.
- `comp_valid`=1, `comp_id`=3 → one write with `pwdata`=3; `comp_ready` pulses once.
- `irq_i`=1 and `comp_valid`=1 in the same IDLE cycle → write issued first, then the read.
- `irq_i` held high, `prdata`=7 each time, `id_ready`=0 → exactly 4 reads, then no `psel` until a pop frees a slot.
- `prdata`=0 → FIFO remains empty, `err_o`=0; `prdata`=5 with `pslverr`=1 → FIFO empty, `err_o`=1.
- Timeout and reset:
  - With `PLIC_CLAIM_TIMEOUT_EN`, `pready`=0 for 16 cycles → bus released, `err_o`=1.
  - `presetn` low during ACCESS → all outputs 0 in the same cycle.
